// File: rtl/sd_req_arbiter_if.sv
// Bundle between block-device clients and the sd request arbiter. The master side drives
// the requests and the HPS acknowledges; the slave side is the arbiter.
interface sd_req_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int LBA_W  = 32
);
  logic [NUM_CH-1:0]       req_rd, req_wr, mounted, sd_ack;
  logic [NUM_CH*LBA_W-1:0] req_lba, sd_lba;
  logic [NUM_CH-1:0]       sd_rd, sd_wr, busy, done, err, grant;

  modport master (
    output req_rd, req_wr, req_lba, mounted, sd_ack,
    input  sd_lba, sd_rd, sd_wr, busy, done, err, grant
  );
  modport slave (
    input  req_rd, req_wr, req_lba, mounted, sd_ack,
    output sd_lba, sd_rd, sd_wr, busy, done, err, grant
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter serialising per-drive sector read/write requests onto hps_io's
// sd_rd/sd_wr/sd_ack handshake, with per-channel busy, done and error reporting.
module sd_req_arbiter_ch (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req_rd,
  input  logic req_wr,
  input  logic mounted,
  input  logic sd_ack,
  input  logic clr_rd,
  input  logic clr_wr,
  output logic pend_rd,
  output logic pend_wr,
  output logic pend_rd_n,
  output logic pend_wr_n,
  output logic ack_rise,
  output logic ack_fall,
  output logic unm_err
);
  logic ack_q;

  // A new request in the same cycle as a clear is kept.
  assign pend_rd_n = (pend_rd & ~clr_rd) | (req_rd & mounted);
  assign pend_wr_n = (pend_wr & ~clr_wr) | (req_wr & mounted);
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      ack_q   <= 1'b0;
      unm_err <= 1'b0;
    end else begin
      pend_rd <= pend_rd_n;
      pend_wr <= pend_wr_n;
      ack_q   <= sd_ack;
      unm_err <= (req_rd | req_wr) & ~mounted;
    end
  end
endmodule

module sd_req_arbiter #(
  parameter int          NUM_CH  = 3,
  parameter int          LBA_W   = 32,
  parameter logic [23:0] TIMEOUT = 24'd14000000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  sd_req_arbiter_if.slave  bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state, state_n;

  logic [CW-1:0]    gidx, gidx_n, ptr, ptr_n, sel, nxt, jj;
  logic [23:0]      cnt, cnt_n;
  logic [NUM_CH-1:0] grant, grant_n, busy, done, done_n, err_q, to_err, clr_rd, clr_wr;
  logic [NUM_CH-1:0] pend_rd, pend_wr, pend_rd_n, pend_wr_n, ack_rise, ack_fall, unm_err;
  logic [NUM_CH-1:0][LBA_W-1:0] lba_q;
  logic             found, lba_ld;
  int               j;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sd_req_arbiter_ch u_ch (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .req_rd    (bus.req_rd[i]),
      .req_wr    (bus.req_wr[i]),
      .mounted   (bus.mounted[i]),
      .sd_ack    (bus.sd_ack[i]),
      .clr_rd    (clr_rd[i]),
      .clr_wr    (clr_wr[i]),
      .pend_rd   (pend_rd[i]),
      .pend_wr   (pend_wr[i]),
      .pend_rd_n (pend_rd_n[i]),
      .pend_wr_n (pend_wr_n[i]),
      .ack_rise  (ack_rise[i]),
      .ack_fall  (ack_fall[i]),
      .unm_err   (unm_err[i])
    );
  end

  // First pending channel at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = CW'(j);
      if (!found && (pend_rd[jj] | pend_wr[jj])) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  assign nxt = (gidx == CW'(NUM_CH - 1)) ? '0 : gidx + CW'(1);

  always_comb begin
    state_n = state;
    gidx_n  = gidx;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant;
    clr_rd  = '0;
    clr_wr  = '0;
    done_n  = '0;
    to_err  = '0;
    lba_ld  = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_n = REQ;
        gidx_n  = sel;
        cnt_n   = '0;
        lba_ld  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) grant_n[i] = (CW'(i) == sel);
      end
      REQ: begin
        if (ack_rise[gidx]) begin
          if (pend_rd[gidx]) clr_rd[gidx] = 1'b1;
          else               clr_wr[gidx] = 1'b1;
          state_n = XFER;
        end else if (TIMEOUT != 24'd0 && cnt == TIMEOUT - 24'd1) begin
          clr_rd[gidx] = 1'b1;
          clr_wr[gidx] = 1'b1;
          to_err[gidx] = 1'b1;
          ptr_n   = nxt;
          grant_n = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      XFER: if (ack_fall[gidx]) begin
        done_n[gidx] = 1'b1;
        ptr_n   = nxt;
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
      busy  <= '0;
      done  <= '0;
      err_q <= '0;
      lba_q <= '0;
    end else begin
      state <= state_n;
      gidx  <= gidx_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      grant <= grant_n;
      busy  <= pend_rd_n | pend_wr_n | grant_n;
      done  <= done_n;
      err_q <= to_err;
      for (int i = 0; i < NUM_CH; i++)
        if (lba_ld && sel == CW'(i)) lba_q[i] <= bus.req_lba[i*LBA_W +: LBA_W];
    end
  end

  // A pending read always wins the strobe; the write waits for the next grant.
  assign bus.sd_rd  = (state == REQ) ? (grant & pend_rd) : '0;
  assign bus.sd_wr  = (state == REQ) ? (grant & pend_wr & ~pend_rd) : '0;
  assign bus.sd_lba = lba_q;
  assign bus.grant  = grant;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.err    = err_q | unm_err;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: an HPS acknowledge model plus a queue of expected transfers.
module tb_sd_req_arbiter;
  localparam int NC = 3;
  localparam int LW = 32;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  sd_req_arbiter_if #(.NUM_CH(NC), .LBA_W(LW)) bus ();
  sd_req_arbiter #(.NUM_CH(NC), .LBA_W(LW), .TIMEOUT(24'd100)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct { int ch; bit wr; logic [LW-1:0] lba; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  int ch, wcyc, scyc;
  bit wr, gd, bok, bad;
  logic [LW-1:0] lba;

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    bus.req_rd = '0; bus.req_wr = '0; bus.sd_ack = '0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic pulse(input logic [NC-1:0] rd, input logic [NC-1:0] wrq);
    bus.req_rd = rd; bus.req_wr = wrq;
    tick();
    bus.req_rd = '0; bus.req_wr = '0;
  endtask

  // HPS model: waits for any strobe, acks rise_dly cycles later, drops ack after hold.
  task automatic serve(input int rise_dly, input int hold,
                       output int och, output int owait, output bit owr, output logic [LW-1:0] olba,
                       output int ostrobe, output bit ogot, output bit obusy_ok, output bit obusy_done);
    och = -1; owait = 0; owr = 0; olba = '0; ostrobe = 0; ogot = 0; obusy_ok = 1; obusy_done = 1;
    while (och < 0 && owait < 200) begin
      for (int i = NC - 1; i >= 0; i--) if (bus.sd_rd[i] | bus.sd_wr[i]) och = i;
      if (och < 0) begin tick(); owait++; end
    end
    if (och < 0) return;
    owr  = bus.sd_wr[och];
    olba = bus.sd_lba[och*LW +: LW];
    for (int c = 0; c < rise_dly + hold + 20; c++) begin
      if (bus.sd_rd[och] | bus.sd_wr[och]) ostrobe++;
      if (bus.done[och]) begin ogot = 1; obusy_done = bus.busy[och]; break; end
      if (!bus.busy[och]) obusy_ok = 0;
      if (c == rise_dly) bus.sd_ack[och] = 1'b1;
      if (c == rise_dly + hold) bus.sd_ack[och] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    bus.mounted = '1; bus.req_rd = '1; bus.req_wr = '0; bus.sd_ack = '0; bus.req_lba = '1;
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (bus.grant !== '0) begin errors++; $display("FAIL rst_grant: got %b want 000", bus.grant); end
    checks++; if (bus.busy !== '0) begin errors++; $display("FAIL rst_busy: got %b want 000", bus.busy); end
    checks++; if ((bus.sd_rd | bus.sd_wr | bus.done | bus.err) !== '0) begin errors++; $display("FAIL rst_strobes: got %b/%b/%b/%b want 0", bus.sd_rd, bus.sd_wr, bus.done, bus.err); end
    checks++; if (bus.sd_lba !== '0) begin errors++; $display("FAIL rst_lba: got %h want 0", bus.sd_lba); end
    bus.req_rd = '0;
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.mounted = 3'b001;
    bus.req_lba = {32'hAAAA, 32'hBBBB, 32'h1234};
    exp_q.push_back('{ch: 0, wr: 1'b0, lba: 32'h1234});
    pulse(3'b001, 3'b000);
    checks++; if (bus.busy[0] !== 1'b1 || bus.sd_rd[0] !== 1'b0) begin errors++; $display("FAIL sr_cycle1: got busy=%b sd_rd=%b want 1/0", bus.busy[0], bus.sd_rd[0]); end
    tick();
    checks++; if (bus.sd_rd[0] !== 1'b1) begin errors++; $display("FAIL sr_latency: got sd_rd=%b want 1", bus.sd_rd[0]); end
    serve(5, 10, ch, wcyc, wr, lba, scyc, gd, bok, bad);
    e = exp_q.pop_front();
    checks++; if (ch != e.ch || wr != e.wr) begin errors++; $display("FAIL sr_chan: got ch=%0d wr=%b want ch=%0d wr=%b", ch, wr, e.ch, e.wr); end
    checks++; if (lba !== e.lba) begin errors++; $display("FAIL sr_lba: got %h want %h", lba, e.lba); end
    checks++; if (scyc != 6) begin errors++; $display("FAIL sr_strobe_len: got %0d want 6", scyc); end
    checks++; if (!gd || !bok || bad) begin errors++; $display("FAIL sr_done_busy: got done=%b busy_ok=%b busy_at_done=%b want 1/1/0", gd, bok, bad); end
    tick();
    checks++; if (bus.done[0] !== 1'b0 || bus.grant !== '0) begin errors++; $display("FAIL sr_after: got done=%b grant=%b want 0/000", bus.done[0], bus.grant); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.mounted = 3'b111;
    bus.req_lba = {32'h2222, 32'h1111, 32'h0000};
    for (int i = 0; i < NC; i++) exp_q.push_back('{ch: i, wr: 1'b0, lba: LW'(i * 32'h1111)});
    pulse(3'b111, 3'b000);
    for (int n = 0; n < NC; n++) begin
      serve(3, 4, ch, wcyc, wr, lba, scyc, gd, bok, bad);
      e = exp_q.pop_front();
      checks++; if (ch != e.ch || lba !== e.lba || !gd) begin errors++; $display("FAIL rr_order%0d: got ch=%0d lba=%h done=%b want ch=%0d lba=%h done=1", n, ch, lba, gd, e.ch, e.lba); end
      checks++; if (wcyc != 1) begin errors++; $display("FAIL rr_gap%0d: got %0d want 1", n, wcyc); end
    end
    exp_q.push_back('{ch: 0, wr: 1'b0, lba: 32'h0});
    exp_q.push_back('{ch: 2, wr: 1'b0, lba: 32'h2222});
    pulse(3'b101, 3'b000);
    for (int n = 0; n < 2; n++) begin
      serve(2, 3, ch, wcyc, wr, lba, scyc, gd, bok, bad);
      e = exp_q.pop_front();
      checks++; if (ch != e.ch || !gd) begin errors++; $display("FAIL rr_wrap%0d: got ch=%0d done=%b want ch=%0d done=1", n, ch, gd, e.ch); end
    end
  endtask

  task automatic test_read_write();
    do_reset();
    bus.mounted = 3'b111;
    bus.req_lba = {32'h0, 32'h5555, 32'h0};
    exp_q.push_back('{ch: 1, wr: 1'b0, lba: 32'h5555});
    exp_q.push_back('{ch: 1, wr: 1'b1, lba: 32'h5555});
    pulse(3'b010, 3'b010);
    serve(2, 3, ch, wcyc, wr, lba, scyc, gd, bok, bad);
    e = exp_q.pop_front();
    checks++; if (ch != e.ch || wr != e.wr || !gd) begin errors++; $display("FAIL rw_first: got ch=%0d wr=%b done=%b want ch=%0d wr=%b", ch, wr, gd, e.ch, e.wr); end
    checks++; if (bad !== 1'b1) begin errors++; $display("FAIL rw_busy_between: got %b want 1", bad); end
    serve(2, 3, ch, wcyc, wr, lba, scyc, gd, bok, bad);
    e = exp_q.pop_front();
    checks++; if (ch != e.ch || wr != e.wr || !gd || lba !== e.lba) begin errors++; $display("FAIL rw_second: got ch=%0d wr=%b done=%b lba=%h want ch=%0d wr=%b lba=%h", ch, wr, gd, lba, e.ch, e.wr, e.lba); end
    checks++; if (bad !== 1'b0 || wcyc != 1) begin errors++; $display("FAIL rw_end: got busy=%b gap=%0d want 0/1", bad, wcyc); end
  endtask

  task automatic test_timeout();
    int w, n;
    do_reset();
    bus.mounted = 3'b111;
    exp_q.push_back('{ch: 2, wr: 1'b1, lba: 32'h0});
    pulse(3'b000, 3'b100);
    w = 0;
    while (!bus.sd_wr[2] && w < 50) begin tick(); w++; end
    e = exp_q.pop_front();
    checks++; if (bus.sd_wr[e.ch] !== e.wr) begin errors++; $display("FAIL to_start: got sd_wr=%b want %b", bus.sd_wr[e.ch], e.wr); end
    n = 0;
    while (bus.sd_wr[2] && n < 300) begin tick(); n++; end
    checks++; if (n != 100) begin errors++; $display("FAIL to_len: got %0d want 100", n); end
    checks++; if (bus.err[2] !== 1'b1 || bus.busy[2] !== 1'b0 || bus.grant !== '0 || bus.done[2] !== 1'b0) begin errors++; $display("FAIL to_abort: got err=%b busy=%b grant=%b done=%b want 1/0/000/0", bus.err[2], bus.busy[2], bus.grant, bus.done[2]); end
    tick();
    checks++; if (bus.err[2] !== 1'b0 || bus.sd_wr !== '0) begin errors++; $display("FAIL to_after: got err=%b sd_wr=%b want 0/000", bus.err[2], bus.sd_wr); end
  endtask

  task automatic test_unmounted_stray();
    do_reset();
    bus.mounted = 3'b101;
    pulse(3'b010, 3'b000);
    checks++; if (bus.err[1] !== 1'b1 || bus.busy[1] !== 1'b0 || bus.sd_rd[1] !== 1'b0) begin errors++; $display("FAIL um_err: got err=%b busy=%b sd_rd=%b want 1/0/0", bus.err[1], bus.busy[1], bus.sd_rd[1]); end
    tick();
    checks++; if (bus.err[1] !== 1'b0 || bus.sd_rd !== '0 || bus.grant !== '0) begin errors++; $display("FAIL um_after: got err=%b sd_rd=%b grant=%b want 0/000/000", bus.err[1], bus.sd_rd, bus.grant); end
    bus.mounted = 3'b111;
    bus.req_lba = {32'h7777, 32'h0, 32'h0};
    exp_q.push_back('{ch: 2, wr: 1'b0, lba: 32'h7777});
    pulse(3'b100, 3'b000);
    fork
      begin
        repeat (5) begin tick(); bus.sd_ack[0] = ~bus.sd_ack[0]; end
        bus.sd_ack[0] = 1'b0;
      end
    join_none
    serve(7, 4, ch, wcyc, wr, lba, scyc, gd, bok, bad);
    e = exp_q.pop_front();
    checks++; if (ch != e.ch || lba !== e.lba || !gd || scyc != 8) begin errors++; $display("FAIL stray_ack: got ch=%0d lba=%h done=%b strobe=%0d want ch=%0d lba=%h done=1 strobe=8", ch, lba, gd, scyc, e.ch, e.lba); end
    checks++; if (bus.done[0] !== 1'b0 || bus.busy[0] !== 1'b0) begin errors++; $display("FAIL stray_ch0: got done=%b busy=%b want 0/0", bus.done[0], bus.busy[0]); end
  endtask

  task automatic test_reset_mid_xfer();
    bit seen;
    do_reset();
    bus.mounted = 3'b001;
    pulse(3'b001, 3'b000);
    tick();
    checks++; if (bus.sd_rd[0] !== 1'b1) begin errors++; $display("FAIL rx_start: got sd_rd=%b want 1", bus.sd_rd[0]); end
    bus.sd_ack[0] = 1'b1;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if ((bus.grant | bus.busy | bus.sd_rd | bus.sd_wr | bus.done | bus.err) !== '0) begin errors++; $display("FAIL rx_reset: got g=%b b=%b r=%b w=%b d=%b e=%b want all 0", bus.grant, bus.busy, bus.sd_rd, bus.sd_wr, bus.done, bus.err); end
    bus.sd_ack[0] = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if ((bus.grant | bus.busy | bus.sd_rd | bus.done | bus.err) !== '0) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rx_late_fall: got activity=%b want 0", seen); end
  endtask

  initial begin
    bus.req_rd = '0; bus.req_wr = '0; bus.sd_ack = '0; bus.mounted = '0; bus.req_lba = '0;
    tick();
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_write();
    test_timeout();
    test_unmounted_stray();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before 40000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
